// File: rtl/bcla_acc_pkg.sv
// Shared types and default widths for the block-CLA sum accumulator.
package bcla_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int IN_W_D  = 16;
  localparam int ACC_W_D = 24;
  localparam int CNT_W_D = 8;
  localparam int BLK_D   = 4;

endpackage

// File: rtl/bcla_sum_accumulator_if.sv
// Sample-in / frame-result-out handshake bundle of the sum accumulator.
// master = upstream/downstream side, slave = the accumulator itself.
interface bcla_sum_accumulator_if
  import bcla_acc_pkg::*;
#(
  parameter int IN_W  = IN_W_D,
  parameter int ACC_W = ACC_W_D,
  parameter int CNT_W = CNT_W_D
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_cnt, out_ovf
  );
endinterface

// File: rtl/bcla_acc_adder.sv
// Block carry-look-ahead adder: carries inside a block are formed directly
// from the block carry-in, block carries ripple from block to block.
// The top block is narrower when ACC_W is not a multiple of BLK.
module bcla_acc_adder
  import bcla_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_D,
  parameter int BLK   = BLK_D
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             cin,
  output logic [ACC_W-1:0] s,
  output logic             cout
);
  localparam int NBLK = (ACC_W + BLK - 1) / BLK;

  logic [NBLK-1:0] blk_g;
  logic [NBLK-1:0] blk_p;
  logic [NBLK:0]   c_blk;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LO = k * BLK;
    localparam int HI = ((k + 1) * BLK > ACC_W) ? ACC_W - 1 : (k + 1) * BLK - 1;
    localparam int BW = HI - LO + 1;

    logic [BW-1:0] g, p, gg, pp, cc;

    assign g = a[HI:LO] & b[HI:LO];
    assign p = a[HI:LO] ^ b[HI:LO];

    // group generate/propagate from the block LSB up to each bit
    always_comb begin
      gg = '0;
      pp = '0;
      gg[0] = g[0];
      pp[0] = p[0];
      for (int i = 1; i < BW; i++) begin
        gg[i] = g[i] | (p[i] & gg[i-1]);
        pp[i] = p[i] & pp[i-1];
      end
    end

    assign blk_g[k] = gg[BW-1];
    assign blk_p[k] = pp[BW-1];

    // look-ahead carries into each bit from the block carry-in
    always_comb begin
      cc = '0;
      cc[0] = c_blk[k];
      for (int i = 1; i < BW; i++) begin
        cc[i] = gg[i-1] | (pp[i-1] & c_blk[k]);
      end
    end

    assign s[HI:LO] = p ^ cc;
  end

  // block carries ripple through the block-level G/P
  always_comb begin
    c_blk = '0;
    c_blk[0] = cin;
    for (int k = 0; k < NBLK; k++) begin
      c_blk[k+1] = blk_g[k] | (blk_p[k] & c_blk[k]);
    end
  end

  assign cout = c_blk[NBLK];
endmodule

// File: rtl/bcla_sum_accumulator.sv
// Accumulates a programmable number of upstream adder sums per frame and
// hands out the frame total with sample count and sticky carry-out flag.
//
// state | meaning
// IDLE  | no frame in progress, next accepted sample starts a frame
// ACC   | frame in progress, adding samples until len_q reached
// DONE  | frame result held on out_*; a new frame may start on delivery
module bcla_sum_accumulator
  import bcla_acc_pkg::*;
#(
  parameter int IN_W  = IN_W_D,
  parameter int ACC_W = ACC_W_D,
  parameter int CNT_W = CNT_W_D,
  parameter int BLK   = BLK_D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [CNT_W-1:0]     len,
  bcla_sum_accumulator_if.slave bus
);
  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_sum, in_ext;
  logic [CNT_W-1:0] cnt, cnt_inc, len_q, len_eff;
  logic [IN_W-1:0]  in_data;
  logic             ovf, carry;
  logic             accept, deliver, start, add;

  assign in_data = bus.in_data;
  assign in_ext  = ACC_W'(in_data);
  assign cnt_inc = cnt + CNT_W'(1);
  assign len_eff = (len == '0) ? CNT_W'(1) : len;

  // ready never looks at in_valid; a held result only blocks when not drained
  assign bus.in_ready = !rst && !clr && ((state != DONE) || bus.out_ready);
  assign accept  = bus.in_valid && bus.in_ready;
  assign deliver = (state == DONE) && bus.out_ready;
  // DONE with accept always coincides with delivery, so it starts a frame
  assign start   = accept && (state != ACC);
  assign add     = accept && (state == ACC);

  bcla_acc_adder #(
    .ACC_W (ACC_W),
    .BLK   (BLK)
  ) u_adder (
    .a    (acc),
    .b    (in_ext),
    .cin  (1'b0),
    .s    (acc_sum),
    .cout (carry)
  );

  // next-state decode
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = (len_eff == CNT_W'(1)) ? DONE : ACC;
    end else if (add && (cnt_inc == len_q)) begin
      state_nxt = DONE;
    end else if (deliver) begin
      state_nxt = IDLE;
    end
  end

  // state, accumulator and frame bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        acc   <= in_ext;
        cnt   <= CNT_W'(1);
        ovf   <= 1'b0;
        len_q <= len_eff;
      end else if (add) begin
        acc <= acc_sum;
        cnt <= cnt_inc;
        ovf <= ovf | carry;
      end
    end
  end

  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = acc;
  assign bus.out_cnt   = cnt;
  assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_bcla_sum_accumulator.sv
// Bench for bcla_sum_accumulator: two instances (24-bit and 17-bit
// accumulator) share all stimulus; a frame-level model predicts results.
module tb_bcla_sum_accumulator;
  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [15:0] in_data;
  logic [7:0]  len;

  int n_tests = 0;
  int n_fail  = 0;

  bcla_sum_accumulator_if #(.IN_W(16), .ACC_W(24), .CNT_W(8)) ifa ();
  bcla_sum_accumulator_if #(.IN_W(16), .ACC_W(17), .CNT_W(8)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.out_ready = out_ready;

  bcla_sum_accumulator #(.IN_W(16), .ACC_W(24), .CNT_W(8), .BLK(4)) dut_a (
    .clk (clk), .rst (rst), .clr (clr), .len (len), .bus (ifa)
  );
  bcla_sum_accumulator #(.IN_W(16), .ACC_W(17), .CNT_W(8), .BLK(4)) dut_b (
    .clk (clk), .rst (rst), .clr (clr), .len (len), .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // frame-level reference: true (unbounded) sum, count, pending result
  bit     m_busy = 0, m_pend = 0;
  longint m_sum = 0, p_sum = 0;
  int     m_cnt = 0, m_len = 0, p_cnt = 0;
  int     n_deliv = 0;

  always @(posedge clk) begin
    bit rdy;
    if (rst) begin
      m_busy = 0; m_pend = 0; m_sum = 0; m_cnt = 0;
    end else if (clr) begin
      m_busy = 0; m_pend = 0;
    end else begin
      rdy = !m_pend || out_ready;
      if (m_pend && out_ready) begin
        m_pend = 0;
        n_deliv++;
      end
      if (in_valid && rdy) begin
        if (!m_busy) begin
          m_len  = (len == 0) ? 1 : int'(len);
          m_sum  = longint'(in_data);
          m_cnt  = 1;
          m_busy = 1;
        end else begin
          m_sum += longint'(in_data);
          m_cnt++;
        end
        if (m_cnt == m_len) begin
          m_pend = 1; m_busy = 0;
          p_sum = m_sum; p_cnt = m_cnt;
        end
      end
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    bit exp_rdy;
    exp_rdy = !rst && !clr && (!m_pend || out_ready);
    check("in_ready_a", longint'(ifa.in_ready), longint'(exp_rdy));
    check("in_ready_b", longint'(ifb.in_ready), longint'(exp_rdy));
    check("out_valid_a", longint'(ifa.out_valid), longint'(m_pend));
    check("out_valid_b", longint'(ifb.out_valid), longint'(m_pend));
    if (m_pend) begin
      check("out_data_a", longint'(ifa.out_data), p_sum & ((longint'(1) << 24) - 1));
      check("out_data_b", longint'(ifb.out_data), p_sum & ((longint'(1) << 17) - 1));
      check("out_cnt_a", longint'(ifa.out_cnt), longint'(p_cnt));
      check("out_cnt_b", longint'(ifb.out_cnt), longint'(p_cnt));
      check("out_ovf_a", longint'(ifa.out_ovf), longint'(p_sum >= (longint'(1) << 24)));
      check("out_ovf_b", longint'(ifb.out_ovf), longint'(p_sum >= (longint'(1) << 17)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int target, cycles;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; len = '0;
    repeat (3) tick();
    check("rst_in_ready", longint'(ifa.in_ready), 0);
    check("rst_out_valid", longint'(ifa.out_valid), 0);
    check("rst_out_data", longint'(ifa.out_data), 0);
    check("rst_out_cnt", longint'(ifa.out_cnt), 0);
    check("rst_out_ovf", longint'(ifb.out_ovf), 0);
    rst = 1'b0;
    tick();

    // len=4, 1+2+3+4
    len = 8'd4; out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    check("d1_valid", longint'(ifa.out_valid), 1);
    check("d1_data", longint'(ifa.out_data), 64'h0A);
    check("d1_cnt", longint'(ifa.out_cnt), 4);
    check("d1_ovf", longint'(ifa.out_ovf), 0);
    check("d1_model", p_sum, 64'h0A);
    tick();
    check("d1_delivered", longint'(ifa.out_valid), 0);

    // len=0 behaves as len=1
    len = 8'd0; out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    check("d2_valid", longint'(ifa.out_valid), 1);
    check("d2_data_a", longint'(ifa.out_data), 64'h00FFFF);
    check("d2_cnt", longint'(ifa.out_cnt), 1);
    check("d2_data_b", longint'(ifb.out_data), 64'h0FFFF);
    check("d2_ovf_b", longint'(ifb.out_ovf), 0);
    out_ready = 1'b1;
    tick();

    // 3 x 0xFFFF: wraps the 17-bit accumulator, not the 24-bit one
    len = 8'd3; in_valid = 1'b1; in_data = 16'hFFFF;
    repeat (3) tick();
    in_valid = 1'b0;
    check("d3_data_b", longint'(ifb.out_data), 64'h0FFFD);
    check("d3_ovf_b", longint'(ifb.out_ovf), 1);
    check("d3_data_a", longint'(ifa.out_data), 64'h2FFFD);
    check("d3_ovf_a", longint'(ifa.out_ovf), 0);
    check("d3_cnt", longint'(ifb.out_cnt), 3);
    tick();

    // stalled result, then deliver + accept in the same cycle
    len = 8'd2; in_valid = 1'b1;
    in_data = 16'h1; tick();
    in_data = 16'h2; tick();
    out_ready = 1'b0; in_data = 16'h55;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("d4_stall_ready", longint'(ifa.in_ready), 0);
      check("d4_stall_data", longint'(ifa.out_data), 64'h3);
      check("d4_stall_valid", longint'(ifa.out_valid), 1);
      tick();
    end
    out_ready = 1'b1; in_data = 16'h10;
    #1;
    check("d4_ready", longint'(ifa.in_ready), 1);
    tick();
    check("d4_b2b_valid", longint'(ifa.out_valid), 0);
    check("d4_b2b_acc", longint'(ifa.out_data), 64'h10);
    check("d4_b2b_cnt", longint'(ifa.out_cnt), 1);
    in_data = 16'h20; tick();
    in_valid = 1'b0;
    check("d4_data", longint'(ifa.out_data), 64'h30);
    check("d4_cnt", longint'(ifa.out_cnt), 2);
    tick();

    // clr mid-frame aborts; sample in the clr cycle is dropped
    len = 8'd8; in_valid = 1'b1; in_data = 16'h10;
    repeat (3) tick();
    clr = 1'b1; in_data = 16'h77;
    #1;
    check("d5_clr_ready", longint'(ifa.in_ready), 0);
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("d5_clr_valid", longint'(ifa.out_valid), 0);
    check("d5_clr_cnt", longint'(ifa.out_cnt), 0);
    tick();
    len = 8'd2; in_valid = 1'b1; in_data = 16'h1;
    repeat (2) tick();
    in_valid = 1'b0;
    check("d5_data", longint'(ifa.out_data), 64'h2);
    check("d5_cnt", longint'(ifa.out_cnt), 2);
    check("d5_ovf", longint'(ifa.out_ovf), 0);

    // clr discards a pending result
    out_ready = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("d6_discard", longint'(ifa.out_valid), 0);
    tick();

    // randomized traffic
    target = n_deliv + 1000;
    cycles = 0;
    while (n_deliv < target && cycles < 80000) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = (($urandom % 4) == 0) ? 16'hFFFF : 16'($urandom);
      out_ready = ($urandom % 3) != 0;
      len       = (($urandom % 40) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'($urandom_range(0, 10));
      clr       = ($urandom % 300) == 0;
      rst       = ($urandom % 3000) == 0;
      tick();
      cycles++;
    end
    rst = 1'b0; clr = 1'b0;
    check("rand_frames", longint'(n_deliv), longint'(target));
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
